// File: rtl/seg_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display_if
// Description : CPU-side bus of the seven-segment scanner: hex value, decimal
//               points, capture strobe and the two live display controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    data_valid;
    logic                    lz_en;
    logic                    enable;

    modport master (output data_in, dp_in, data_valid, lz_en, enable);
    modport slave  (input  data_in, dp_in, data_valid, lz_en, enable);
endinterface
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Multiplexed seven-segment driver with frame-synchronous update,
//               decimal points, leading-zero blanking and selectable polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    seg_scan_display_if.slave          cpu,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [7:0]                 seg,
    output logic                       frame_tick
);
    localparam int                    DIV_W    = $clog2(SCAN_DIV);
    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            SEG_OFF  = {8{ACTIVE_LOW}};

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d, dp_disp_q, dp_disp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    tick, boundary, blank;
    logic [IDX_W-1:0]        hi_idx;
    logic [3:0]              cur_nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;  4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;  4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;  4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;  4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;  4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;  4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;  default: hex_to_seg = 7'h71;
        endcase
    endfunction

    // Highest non-zero nibble; an all-zero value reports 0 so digit 0 stays lit.
    always_comb begin
        hi_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (disp_q[4*k +: 4] != 4'h0) begin
                hi_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        tick         = (div_cnt_q == DIV_LAST);
        boundary     = tick && (idx_q == IDX_LAST);
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        shadow_d     = cpu.data_valid ? cpu.data_in : shadow_q;
        dp_shadow_d  = cpu.data_valid ? cpu.dp_in   : dp_shadow_q;
        // A strobe on the boundary edge bypasses the shadow straight to the display.
        disp_d       = boundary ? shadow_d    : disp_q;
        dp_disp_d    = boundary ? dp_shadow_d : dp_disp_q;
        frame_tick_d = boundary;

        cur_nib      = 4'(disp_q >> {idx_q, 2'b00});
        blank        = cpu.lz_en && (idx_q > hi_idx);
        seg_d        = {dp_disp_q[idx_q], blank ? 7'h00 : hex_to_seg(cur_nib)};
        an_d         = cpu.enable ? (NUM_DIGITS'(1) << idx_q) : '0;
        seg_d        = seg_d ^ SEG_OFF;
        an_d         = an_d  ^ AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            dp_shadow_q  <= '0;
            disp_q       <= '0;
            dp_disp_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            dp_shadow_q  <= dp_shadow_d;
            disp_q       <= disp_d;
            dp_disp_q    <= dp_disp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;
endmodule
`default_nettype wire
